csr_file: RTL

Parametrised user-mode CSR file for the RISC-V core, successor to the fixed 32-bit CSR bank. It adds atomic read-modify-write operations (RW/RS/RC) and 64-bit cycle/instret counters. It also implements trap entry/exit with UIE/UPIE stacking, registered interrupt-pending sampling and vectored trap targets. It sits beside the register file in the execute stage and feeds the PC-select logic with trap and return addresses.

---
 rtl/csr_file_if.sv | 20 ++
 rtl/csr_file.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/csr_file_if.sv
// rtl/csr_file_if.sv - CSR access port bundle between the execute stage and csr_file
interface csr_file_if #(
  parameter int XLEN = 32
);
  logic [11:0]     iCSRAddr;
  logic [1:0]      iCSROp;
  logic [XLEN-1:0] iCSRWData;
  logic [XLEN-1:0] oCSRRData;
  logic            oIllegal;

  modport master (
    output iCSRAddr, iCSROp, iCSRWData,
    input  oCSRRData, oIllegal
  );

  modport slave (
    input  iCSRAddr, iCSROp, iCSRWData,
    output oCSRRData, oIllegal
  );
endinterface

// File: rtl/csr_file.sv
// rtl/csr_file.sv - user-mode CSR file with RW/RS/RC access, 64-bit counters and trap entry/exit
module csr_file #(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 4
) (
  input  logic               iCLK,
  input  logic               iRST,
  csr_file_if.slave          csr,
  input  logic               iTrap,
  input  logic [XLEN-1:0]    iCause,
  input  logic [XLEN-1:0]    iTrapPC,
  input  logic [XLEN-1:0]    iTrapVal,
  input  logic               iURET,
  input  logic               iRetire,
  input  logic               iSoftIRQ,
  input  logic               iTimerIRQ,
  input  logic               iExtIRQ,
  input  logic [NUM_IRQ-1:0] iIRQ,
  output logic [XLEN-1:0]    oTrapVector,
  output logic [XLEN-1:0]    oEPC,
  output logic               oIntPending,
  output logic [XLEN-1:0]    oIntCause
);
  localparam int IW = XLEN - 1;
  localparam logic [XLEN-1:0] IRQ_MASK = ((XLEN'(1) << NUM_IRQ) - XLEN'(1)) << 16;
  localparam logic [XLEN-1:0] UIE_MASK = IRQ_MASK | XLEN'(32'h0000_0111);

  logic               status_uie, status_upie;
  logic [7:0]         fcsr_q;
  logic [XLEN-1:0]    uie_q, utvec_q, uscratch_q, uepc_q, ucause_q, utval_q;
  logic               usip_q, utip_q, ueip_q;
  logic [NUM_IRQ-1:0] irq_q;
  logic [63:0]        cycle_q, instret_q;

  logic [XLEN-1:0]    uip_rd, rdata, nv, pend;
  logic               impl, ro, wr_attempt, illegal, csr_we;
  logic [IW-1:0]      int_idx;

  always_comb begin
    uip_rd              = '0;
    uip_rd[0]           = usip_q | iSoftIRQ;
    uip_rd[4]           = utip_q;
    uip_rd[8]           = ueip_q;
    uip_rd[16 +: NUM_IRQ] = irq_q;
  end

  always_comb begin
    rdata = '0;
    impl  = 1'b1;
    ro    = 1'b0;
    case (csr.iCSRAddr)
      12'h000: begin rdata[0] = status_uie; rdata[4] = status_upie; end
      12'h001: rdata = XLEN'(fcsr_q[4:0]);
      12'h002: rdata = XLEN'(fcsr_q[7:5]);
      12'h003: rdata = XLEN'(fcsr_q);
      12'h004: rdata = uie_q;
      12'h005: rdata = utvec_q;
      12'h040: rdata = uscratch_q;
      12'h041: rdata = uepc_q;
      12'h042: rdata = ucause_q;
      12'h043: rdata = utval_q;
      12'h044: rdata = uip_rd;
      12'hC00: begin rdata = cycle_q[XLEN-1:0];   ro = 1'b1; end
      12'hC02: begin rdata = instret_q[XLEN-1:0]; ro = 1'b1; end
      12'hC80: begin
        ro = 1'b1;
        if (XLEN == 32) rdata = XLEN'(cycle_q[63:32]);
        else            impl  = 1'b0;
      end
      12'hC82: begin
        ro = 1'b1;
        if (XLEN == 32) rdata = XLEN'(instret_q[63:32]);
        else            impl  = 1'b0;
      end
      default: impl = 1'b0;
    endcase
  end

  // RS/RC with a zero mask is a pure read and must stay legal on counters
  always_comb begin
    nv         = rdata;
    wr_attempt = 1'b0;
    case (csr.iCSROp)
      2'b01: begin nv = csr.iCSRWData;          wr_attempt = 1'b1; end
      2'b10: begin nv = rdata | csr.iCSRWData;  wr_attempt = |csr.iCSRWData; end
      2'b11: begin nv = rdata & ~csr.iCSRWData; wr_attempt = |csr.iCSRWData; end
      default: ;
    endcase
    illegal = (csr.iCSROp != 2'b00) && (!impl || (ro && wr_attempt));
    csr_we  = wr_attempt && !illegal;
  end

  assign csr.oCSRRData = rdata;
  assign csr.oIllegal  = illegal;

  always_comb begin
    pend    = uie_q & uip_rd;
    int_idx = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (pend[i]) int_idx = IW'(i);
    end
  end

  assign oIntPending = status_uie & (|pend);
  assign oIntCause   = {1'b1, int_idx};
  assign oEPC        = uepc_q;

  always_comb begin
    oTrapVector = {utvec_q[XLEN-1:2], 2'b00};
    if (utvec_q[1:0] == 2'b01 && iCause[XLEN-1])
      oTrapVector = {utvec_q[XLEN-1:2], 2'b00} + {iCause[XLEN-3:0], 2'b00};
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      status_uie  <= 1'b0;
      status_upie <= 1'b0;
      fcsr_q      <= '0;
      uie_q       <= '0;
      utvec_q     <= '0;
      uscratch_q  <= '0;
      uepc_q      <= '0;
      ucause_q    <= '0;
      utval_q     <= '0;
      usip_q      <= 1'b0;
      utip_q      <= 1'b0;
      ueip_q      <= 1'b0;
      irq_q       <= '0;
      cycle_q     <= '0;
      instret_q   <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (iRetire) instret_q <= instret_q + 64'd1;
      utip_q <= iTimerIRQ;
      ueip_q <= iExtIRQ;
      irq_q  <= iIRQ;
      if (iTrap) begin
        uepc_q      <= {iTrapPC[XLEN-1:2], 2'b00};
        ucause_q    <= iCause;
        utval_q     <= iTrapVal;
        status_upie <= status_uie;
        status_uie  <= 1'b0;
      end else if (iURET) begin
        status_uie  <= status_upie;
        status_upie <= 1'b1;
      end else if (csr_we) begin
        case (csr.iCSRAddr)
          12'h000: begin status_uie <= nv[0]; status_upie <= nv[4]; end
          12'h001: fcsr_q[4:0] <= nv[4:0];
          12'h002: fcsr_q[7:5] <= nv[2:0];
          12'h003: fcsr_q      <= nv[7:0];
          12'h004: uie_q       <= nv & UIE_MASK;
          12'h005: utvec_q     <= nv;
          12'h040: uscratch_q  <= nv;
          12'h041: uepc_q      <= {nv[XLEN-1:2], 2'b00};
          12'h042: ucause_q    <= nv;
          12'h043: utval_q     <= nv;
          12'h044: usip_q      <= nv[0];
          default: ;
        endcase
      end
    end
  end
endmodule
